bus_copy_master: RTL and testbench

Bus initiator that copies a block of 64-bit words from one address range to another over the shared master/slave bus. It drives the master port of the bus (`m_req`, `m_wr`, `m_addr`, `m_dout`) and consumes `m_grant` / `m_din`, acting as the master end of the interface. It alternates one read and one write per word until the programmed length is exhausted. Control is a simple start/busy/done handshake from a local controller.

---
 rtl/bus_copy_master.sv | 137 +++++++++++++
 tb/tb_bus_copy_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_master.sv
// bus_copy_master: bus initiator that copies a block of 64-bit words from a
// source range to a destination range, one read then one write per word.
// All bus-side outputs are registered, so nothing depends combinationally
// on m_grant.
module bus_copy_master #(
    parameter int ADDR_STEP = 1,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count,
    output logic             m_req,
    output logic             m_wr,
    output logic [15:0]      m_addr,
    output logic [63:0]      m_dout,
    input  logic             m_grant,
    input  logic [63:0]      m_din
);

    localparam logic [15:0] STEP = 16'(ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t           r_state;
    logic [15:0]      r_src;
    logic [15:0]      r_dst;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_count;
    logic [63:0]      r_buf;
    logic             r_req;
    logic             r_wr;
    logic [15:0]      r_addr;
    logic             r_busy;
    logic             r_done;

    // Copy sequencer. Bus outputs are loaded together with the state they
    // belong to, so m_req stays high across READ<->WRITE without a gap.
    // Abort takes priority over grant and leaves buf/pointers untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_buf   <= '0;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= src_addr;
                        r_dst   <= dst_addr;
                        r_rem   <= length;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        if (length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_req   <= 1'b1;
                            r_wr    <= 1'b0;
                            r_addr  <= src_addr;
                        end
                    end
                end
                S_READ: begin
                    if (abort) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_wr    <= 1'b0;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else if (m_grant) begin
                        r_buf   <= m_din;
                        r_src   <= r_src + STEP;
                        r_state <= S_WRITE;
                        r_wr    <= 1'b1;
                        r_addr  <= r_dst;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        // The word already held in buf is simply dropped.
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_wr    <= 1'b0;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else if (m_grant) begin
                        r_dst   <= r_dst + STEP;
                        r_count <= r_count + LEN_W'(1);
                        r_rem   <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= S_DONE;
                            r_req   <= 1'b0;
                            r_wr    <= 1'b0;
                            r_addr  <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_wr    <= 1'b0;
                            // r_src was already advanced by the read.
                            r_addr  <= r_src;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign count  = r_count;
    assign m_req  = r_req;
    assign m_wr   = r_wr;
    assign m_addr = r_addr;
    assign m_dout = r_buf;

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: expected bus transfers and done pulses are queued
// by the stimulus; a monitor pops and compares them as the DUT presents them.
module tb_bus_copy_master;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  length;
    logic        busy, done;
    logic [7:0]  count;
    logic        m_req, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic        m_grant;
    logic [63:0] m_din;

    logic [63:0] mem [0:15];
    assign m_din = mem[m_addr[3:0]];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } xact_t;

    xact_t      exp_q[$];
    logic [7:0] done_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    bus_copy_master #(.ADDR_STEP(1), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .count(count),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
        .m_grant(m_grant), .m_din(m_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic xact_t mk(input logic wr, input logic [15:0] a, input logic [63:0] d);
        xact_t x;
        x.wr = wr; x.addr = a; x.data = d;
        return x;
    endfunction

    // Monitor: a granted, non-aborted request completes at the next edge.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (m_req && m_grant && !abort) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL xact_unexpected: got wr=%b addr=%h expected none", m_wr, m_addr);
                end else begin
                    xact_t x;
                    x = exp_q.pop_front();
                    chk("xact_wr", m_wr, x.wr);
                    chk("xact_addr", m_addr, x.addr);
                    if (x.wr) chk("xact_data", m_dout, x.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL done_unexpected: got done=1 count=%0d expected no pulse", count);
                end else begin
                    chk("done_count", count, done_q.pop_front());
                end
            end
        end
    end

    task automatic start_job(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the start edge until done; k0 cycles already elapsed.
    task automatic wait_done(input string nm, input int k0, input int exp_k);
        int k;
        k = k0;
        while (!done && k < k0 + 100) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(k), 64'(exp_k));
        @(negedge clk);
        chk({nm, "_pulse_width"}, done, 1'b0);
        chk({nm, "_busy_drop"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; m_grant = 1'b1;
        src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", m_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", m_addr, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_count", count, 8'h0);
        chk("rst_dout", m_dout, 64'h0);

        // Basic copy
        mem[0] = 64'h0000_0000_FFFF_FFFF;
        mem[1] = 64'h0000_0000_1234_5678;
        exp_q.push_back(mk(1'b0, 16'h0100, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h0110, 64'h0000_0000_FFFF_FFFF));
        exp_q.push_back(mk(1'b0, 16'h0101, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h0111, 64'h0000_0000_1234_5678));
        done_q.push_back(8'd2);
        start_job(16'h0100, 16'h0110, 8'd2);
        chk("basic_req_latency", m_req, 1'b1);
        chk("basic_busy", busy, 1'b1);
        wait_done("basic_done_cycle", 0, 4);
        chk("basic_count_hold", count, 8'd2);

        // Grant stall: 3 withheld cycles in the first READ
        exp_q.push_back(mk(1'b0, 16'h0100, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h0110, 64'h0000_0000_FFFF_FFFF));
        exp_q.push_back(mk(1'b0, 16'h0101, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h0111, 64'h0000_0000_1234_5678));
        done_q.push_back(8'd2);
        m_grant = 1'b0;
        start_job(16'h0100, 16'h0110, 8'd2);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", m_req, 1'b1);
            chk("stall_wr", m_wr, 1'b0);
            chk("stall_addr", m_addr, 16'h0100);
            @(negedge clk);
        end
        m_grant = 1'b1;
        wait_done("stall_done_cycle", 3, 7);

        // Zero length
        done_q.push_back(8'd0);
        start_job(16'h0100, 16'h0110, 8'd0);
        chk("zero_req", m_req, 1'b0);
        chk("zero_busy", busy, 1'b1);
        wait_done("zero_done_cycle", 0, 0);
        chk("zero_req_after", m_req, 1'b0);

        // Address wrap
        mem[15] = 64'hAAAA_0000_0000_000F;
        mem[0]  = 64'h5555_0000_0000_0000;
        exp_q.push_back(mk(1'b0, 16'hFFFF, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h01FF, 64'hAAAA_0000_0000_000F));
        exp_q.push_back(mk(1'b0, 16'h0000, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h0200, 64'h5555_0000_0000_0000));
        done_q.push_back(8'd2);
        start_job(16'hFFFF, 16'h01FF, 8'd2);
        wait_done("wrap_done_cycle", 0, 4);

        // Abort in the WRITE of word 2 of a 4-word job
        mem[0] = 64'h0123_4567_89AB_CDEF;
        mem[1] = 64'hFEDC_BA98_7654_3210;
        exp_q.push_back(mk(1'b0, 16'h0200, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h0300, 64'h0123_4567_89AB_CDEF));
        exp_q.push_back(mk(1'b0, 16'h0201, 64'h0));
        done_q.push_back(8'd1);
        start_job(16'h0200, 16'h0300, 8'd4);
        repeat (3) @(negedge clk);
        chk("abort_in_write", m_wr, 1'b1);
        chk("abort_write_addr", m_addr, 16'h0301);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", done, 1'b1);
        chk("abort_req_low", m_req, 1'b0);
        @(negedge clk);
        chk("abort_single_pulse", done, 1'b0);
        chk("abort_idle_busy", busy, 1'b0);

        // Reset during READ of a 3-word job, then restart
        start_job(16'h0400, 16'h0500, 8'd3);
        chk("rstjob_in_read", m_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstjob_req", m_req, 1'b0);
        chk("rstjob_wr", m_wr, 1'b0);
        chk("rstjob_addr", m_addr, 16'h0);
        chk("rstjob_busy", busy, 1'b0);
        chk("rstjob_done", done, 1'b0);
        chk("rstjob_count", count, 8'h0);
        chk("rstjob_dout", m_dout, 64'h0);
        repeat (3) @(negedge clk);
        mem[0] = 64'hDEAD_BEEF_0000_0001;
        exp_q.push_back(mk(1'b0, 16'h0100, 64'h0));
        exp_q.push_back(mk(1'b1, 16'h0600, 64'hDEAD_BEEF_0000_0001));
        done_q.push_back(8'd1);
        start_job(16'h0100, 16'h0600, 8'd1);
        wait_done("restart_done_cycle", 0, 2);
        chk("restart_count", count, 8'd1);

        repeat (3) @(negedge clk);
        chk("xact_queue_drained", 64'(exp_q.size()), 64'h0);
        chk("done_queue_drained", 64'(done_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
